// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction register and an 8-deep return stack.
// Decodes jumps, subroutine calls/returns and flag-conditional relative branches.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        enablePC,
    input  logic [18:0] instrIn,
    input  logic        Zero,
    input  logic        Carry,
    output logic [11:0] PC,
    output logic [18:0] allBits,
    output logic        instrValid,
    output logic        stackEmpty,
    output logic        stackFull,
    output logic        stackError
);

    localparam logic [4:0] OpJmp = 5'b11100;
    localparam logic [4:0] OpJsb = 5'b11101;
    localparam logic [4:0] OpRet = 5'b11110;
    localparam logic [2:0] OpBranch = 3'b101;
    localparam int unsigned StackDepth = 8;

    logic [11:0] pcQ, pcD;
    logic [18:0] allBitsQ;
    logic        instrValidQ;
    logic [3:0]  ptrQ, ptrD;
    logic        errQ, errD;
    logic [11:0] stackMem [StackDepth];

    logic [4:0]  opcode;
    logic [11:0] pcPlus1;
    logic [11:0] branchTarget;
    logic        condTrue;
    logic        doPush;
    logic [2:0]  pushIdx;
    logic [2:0]  popIdx;

    assign stackEmpty = (ptrQ == 4'd0);
    assign stackFull  = (ptrQ == 4'd8);

    always_comb begin
        opcode       = instrIn[18:14];
        pcPlus1      = pcQ + 12'd1;
        branchTarget = pcPlus1 + {{4{instrIn[7]}}, instrIn[7:0]};
        pushIdx      = ptrQ[2:0];
        // With ptr==8 the low bits are 0, so subtracting 1 correctly selects entry 7.
        popIdx       = ptrQ[2:0] - 3'd1;

        unique case (instrIn[15:14])
            2'b00:   condTrue = Zero;
            2'b01:   condTrue = ~Zero;
            2'b10:   condTrue = Carry;
            default: condTrue = ~Carry;
        endcase

        pcD    = pcPlus1;
        ptrD   = ptrQ;
        errD   = errQ;
        doPush = 1'b0;

        if (opcode == OpJmp) begin
            pcD = instrIn[11:0];
        end else if (opcode == OpJsb) begin
            if (!stackFull) begin
                doPush = 1'b1;
                ptrD   = ptrQ + 4'd1;
                pcD    = instrIn[11:0];
            end else begin
                errD = 1'b1;
            end
        end else if (opcode == OpRet) begin
            if (!stackEmpty) begin
                ptrD = ptrQ - 4'd1;
                pcD  = stackMem[popIdx];
            end else begin
                errD = 1'b1;
            end
        end else if (opcode[4:2] == OpBranch) begin
            if (condTrue) begin
                pcD = branchTarget;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcQ         <= 12'd0;
            allBitsQ    <= 19'd0;
            instrValidQ <= 1'b0;
            ptrQ        <= 4'd0;
            errQ        <= 1'b0;
        end else if (enablePC) begin
            pcQ         <= pcD;
            allBitsQ    <= instrIn;
            instrValidQ <= 1'b1;
            ptrQ        <= ptrD;
            errQ        <= errD;
        end
    end

    // Stack contents need no reset; only the pointer defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && enablePC && doPush) begin
            stackMem[pushIdx] <= pcPlus1;
        end
    end

    assign PC         = pcQ;
    assign allBits    = allBitsQ;
    assign instrValid = instrValidQ;
    assign stackError = errQ;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL provide: rst  input  1  reset; synchronous and active-high, sampled on rising clk.
REQ-003 SHALL provide: enablePC  input  1  advance enable; 0 = stall, all state held.
REQ-004 SHALL provide: instrIn  input  19  instruction word read combinationally from instruction memory at address PC.
REQ-005 SHALL provide: Zero  input  1  registered zero flag from the flag stage.
REQ-006 SHALL provide: Carry  input  1  registered carry flag from the flag stage.
REQ-007 SHALL provide: PC  output  12  current instruction address.
REQ-008 SHALL provide: allBits  output  19  instruction register driving the controller.
REQ-009 SHALL provide: instrValid  output  1  high when allBits holds a fetched instruction.
REQ-010 SHALL provide: stackEmpty  output  1  return stack holds 0 entries.
REQ-011 SHALL provide: stackFull  output  1  return stack holds 8 entries.
REQ-012 SHALL provide: stackError  output  1  sticky flag: overflowed push or underflowed pop.

Function
REQ-013 SHALL update state only on a rising clk with rst=0 and enablePC=1; with enablePC=0, PC, allBits, instrValid, stack and stackError SHALL hold.
REQ-014 On an advance, allBits SHALL load instrIn, instrValid SHALL go 1, and PC SHALL load nextPC decoded from instrIn; one-cycle fetch latency.
REQ-015 Decode classes (bits 18:14): 11100 JMP, 11101 JSB, 11110 RET; 101xx conditional branch; all other codes sequential.
REQ-016 Sequential: nextPC = PC+1 modulo 4096 (4095 wraps to 0).
REQ-017 Conditional branch: condition instrIn[15:14] = 00 Zero, 01 !Zero, 10 Carry, 11 !Carry, evaluated on the flags in the advance cycle.
REQ-018 Condition true: nextPC = PC+1+signext(instrIn[7:0]) modulo 4096; condition false: nextPC = PC+1.
REQ-019 JMP: nextPC = instrIn[11:0].
REQ-020 JSB with stack not full: push PC+1 (mod 4096), nextPC = instrIn[11:0].
REQ-021 JSB with stack full: no push, nextPC = PC+1, stackError set to 1.
REQ-022 RET with stack not empty: pop, nextPC = popped address.
REQ-023 RET with stack empty: no pop, nextPC = PC+1, stackError set to 1.
REQ-024 Return stack: 8 entries x 12 bits, LIFO, pointer 0..8; stackEmpty = (ptr==0), stackFull = (ptr==8), both combinational from the pointer.
REQ-025 stackError SHALL stay 1 until reset; it does not affect subsequent push/pop behaviour.
REQ-026 Instruction types are mutually exclusive per cycle; a single advance performs at most one push or one pop.

Reset
REQ-027 rst=1 at a rising edge SHALL set PC=0, allBits=0, instrValid=0, stack pointer=0, stackError=0, regardless of enablePC.
REQ-028 Reset SHALL take priority over an in-progress JSB/RET/branch in the same cycle; no push or pop is committed.
REQ-029 Outputs after reset: stackEmpty=1, stackFull=0; stack entry contents are don't-care.

Verification
REQ-030 Reset then sequential code, enablePC=1 for 3 cycles -> PC 0,1,2,3; allBits follows instrIn; instrValid=1 from first advance.
REQ-031 At PC=0x010, branch cond 00, offset 0xFE, Zero=1 -> PC=0x00F; same with Zero=0 -> PC=0x011.
REQ-032 At PC=0x020, JSB 0x300 -> PC=0x300, stackEmpty=0; then RET -> PC=0x021, stackEmpty=1.
REQ-033 Nine consecutive JSBs from empty -> stackFull=1 after 8th; 9th gives PC=target-of-8th+1, stackError=1; later RET pops 8th return address.
REQ-034 RET with empty stack at PC=0xFFF -> PC=0x000, stackError=1; enablePC=0 for 2 cycles mid-sequence -> all outputs held.
REQ-035 rst asserted during a JSB advance with enablePC=1 -> PC=0, stack empty, stackError=0 next cycle.
